param_ring_counter: RTL and testbench
=====================================

Name: param_ring_counter

Overview:
- Parametrised successor to the team's fixed 8-bit ring counter.
- Counts a run-time programmable number of enabled advances, then flags completion.
- Drives a RING_W-bit ring output in one-hot or Johnson (twisted-ring) mode.
- Supports one-shot or auto-reload operation, explicit start/restart and pause via en; used as a sequencing/timing strobe source in controller datapaths.

Parameters:
- CNT_W, 8, width of terminal-count input and internal counter
- RING_W, 8, width of ring output (>=2)

Ports:
- clk  input  1  system clock, rising-edge
- rst  input  1  asynchronous, active-high reset
- en  input  1  advance enable; 0 freezes all state except start handling
- start  input  1  latch config and begin a run (restart if busy)
- i_num_cnt  input  CNT_W  number of advances per run (N)
- i_mode  input  1  0 = one-hot ring, 1 = Johnson ring
- i_auto_reload  input  1  1 = rerun automatically after each done
- out  output  RING_W  ring pattern
- o_cnt  output  CNT_W  advances completed in current run (0..N-1)
- o_busy  output  1  run in progress
- is_done_o  output  1  one-cycle completion pulse

Behaviour:
- Reset (async, immediate):
  - FSM = IDLE
  - o_cnt = 0, o_busy = 0, is_done_o = 0
  - out = seed of mode 0, i.e. {0..0,1}
  - latched config: N = 0, mode = 0, reload = 0
- FSM states: IDLE, RUN. All outputs are registered.
- start sampled high at a clock edge, in any state:
  - latch N = i_num_cnt, mode = i_mode, reload = i_auto_reload
  - o_cnt = 0, is_done_o = 0
  - out = seed: one-hot {0..0,1}; Johnson all-zeros
  - if N != 0: FSM = RUN, o_busy = 1
  - if N == 0: FSM = IDLE, o_busy = 0, is_done_o = 1 for one cycle; no advance occurs
  - start takes priority over en on the same edge; no advance on the start edge
- RUN, edge with en = 1 (an "advance"):
  - out steps: one-hot rotates left (MSB wraps to bit 0); Johnson shifts left inserting ~out[RING_W-1]
  - if o_cnt == N-1 (Nth advance): is_done_o = 1 for exactly one cycle, o_cnt = 0
    - reload = 1: stay RUN, o_busy stays 1
    - reload = 0: go IDLE, o_busy = 0
  - otherwise o_cnt += 1
- RUN, edge with en = 0: all state holds; is_done_o = 0.
- IDLE: out and o_cnt hold their last value; en is ignored.
- Config inputs (i_num_cnt, i_mode, i_auto_reload) are ignored except on start edges.
- Ring position is not reset at done, including in auto-reload; only start or rst reseeds out.
- N = 1: every advance produces done. With reload = 1 and en held high, is_done_o stays high continuously (one pulse per cycle).
- Latency: start at edge E0, en held high → Nth advance at edge EN → is_done_o high during the cycle after EN.
- Counter arithmetic is unsigned CNT_W bits; N max = 2^CNT_W - 1. o_cnt never reaches N.
- rst asserted mid-run aborts immediately to reset values; no done pulse is generated.

Test Plan:
- Reset/seed: rst high 50 ns then low → out = 8'h01, o_cnt = 0, o_busy = 0, is_done_o = 0; en = 1 without start → nothing changes.
- One-hot one-shot: start with N = 10, mode 0, reload 0, en = 1 → exactly one is_done_o pulse, 10 edges after start; out = 8'b0000_0100; o_busy falls the same cycle; o_cnt = 0.
- Johnson: N = 10, mode 1 → out sequence 00,01,03,07,0F,1F,3F,7F,FF,FE,FC; done coincides with FC.
- Auto-reload with pause:
  - N = 3, reload 1, en toggling 1,1,0,1,1,1,1 → done after the 3rd and 6th advances only; o_busy stays 1.
  - en = 0 cycles hold out and o_cnt.
- Edge cases:
  - start with N = 0 → single is_done_o pulse next cycle, o_busy never high.
  - start with N = 1, reload 1, en high → is_done_o continuously high.
- Restart/abort:
  - start during RUN at o_cnt = 5 → o_cnt = 0, out reseeded, new N used.
  - rst mid-run → immediate reset values, no done pulse.

Source files
------------

// File: rtl/param_ring_counter.sv
// -----------------------------------------------------------------------------
// param_ring_counter
//
// Purpose:
//   Programmable-length ring counter used as a sequencing/timing strobe
//   source. A run is begun by start, which latches the terminal count N, the
//   ring mode and the auto-reload flag. Each enabled clock edge while running
//   is one "advance": the ring output steps and the advance counter
//   increments. On the Nth advance a one-cycle completion pulse is raised and
//   the run either ends (one-shot) or continues (auto-reload).
//
// Parameters:
//   CNT_W  - width of the terminal count and of the advance counter
//   RING_W - width of the ring output (must be >= 2)
//
// Ports:
//   clk           in   rising-edge clock
//   rst           in   asynchronous active-high reset
//   en            in   advance enable (only meaningful while running)
//   start         in   latch config and (re)start a run; wins over en
//   i_num_cnt     in   advances per run (N); N = 0 gives an immediate done
//   i_mode        in   0 = one-hot ring, 1 = Johnson (twisted) ring
//   i_auto_reload in   1 = keep running after each completion
//   out           out  ring pattern
//   o_cnt         out  advances completed in the current run (0..N-1)
//   o_busy        out  run in progress
//   is_done_o     out  one-cycle completion pulse
// -----------------------------------------------------------------------------
module param_ring_counter #(
    parameter int CNT_W  = 8,
    parameter int RING_W = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              en,
    input  logic              start,
    input  logic [CNT_W-1:0]  i_num_cnt,
    input  logic              i_mode,
    input  logic              i_auto_reload,
    output logic [RING_W-1:0] out,
    output logic [CNT_W-1:0]  o_cnt,
    output logic              o_busy,
    output logic              is_done_o
);

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_RUN  = 1'b1
    } state_t;

    localparam logic [RING_W-1:0] ONEHOT_SEED = {{(RING_W-1){1'b0}}, 1'b1};
    localparam logic [CNT_W-1:0]  CNT_ONE     = {{(CNT_W-1){1'b0}}, 1'b1};

    state_t             state_q, state_d;
    logic [CNT_W-1:0]   n_q, n_d;
    logic               mode_q, mode_d;
    logic               reload_q, reload_d;
    logic [RING_W-1:0]  ring_q, ring_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic               done_q, done_d;

    logic [RING_W-1:0]  ring_step;
    logic               last_adv;

    // One-hot rotates the MSB back into bit 0; Johnson feeds back its
    // inverted MSB, giving a 2*RING_W-long sequence from an all-zero seed.
    always_comb begin
        if (mode_q) begin
            ring_step = {ring_q[RING_W-2:0], ~ring_q[RING_W-1]};
        end else begin
            ring_step = {ring_q[RING_W-2:0], ring_q[RING_W-1]};
        end
    end

    // Only evaluated while running, where N is never zero, so N-1 cannot wrap.
    assign last_adv = (cnt_q == (n_q - CNT_ONE));

    always_comb begin
        state_d  = state_q;
        n_d      = n_q;
        mode_d   = mode_q;
        reload_d = reload_q;
        ring_d   = ring_q;
        cnt_d    = cnt_q;
        done_d   = 1'b0;

        if (start) begin
            n_d      = i_num_cnt;
            mode_d   = i_mode;
            reload_d = i_auto_reload;
            cnt_d    = '0;
            ring_d   = i_mode ? '0 : ONEHOT_SEED;
            if (i_num_cnt != '0) begin
                state_d = ST_RUN;
            end else begin
                // Zero-length run completes at once without advancing.
                state_d = ST_IDLE;
                done_d  = 1'b1;
            end
        end else if ((state_q == ST_RUN) && en) begin
            ring_d = ring_step;
            if (last_adv) begin
                done_d = 1'b1;
                cnt_d  = '0;
                // Ring position deliberately carries over into the next run.
                if (!reload_q) begin
                    state_d = ST_IDLE;
                end
            end else begin
                cnt_d = cnt_q + CNT_ONE;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= ST_IDLE;
            n_q      <= '0;
            mode_q   <= 1'b0;
            reload_q <= 1'b0;
            ring_q   <= ONEHOT_SEED;
            cnt_q    <= '0;
            done_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            n_q      <= n_d;
            mode_q   <= mode_d;
            reload_q <= reload_d;
            ring_q   <= ring_d;
            cnt_q    <= cnt_d;
            done_q   <= done_d;
        end
    end

    assign out       = ring_q;
    assign o_cnt     = cnt_q;
    assign o_busy    = (state_q == ST_RUN);
    assign is_done_o = done_q;

endmodule

// File: tb/tb_param_ring_counter.sv
module tb_param_ring_counter;

    logic       clk = 1'b0;
    logic       rst;
    logic       en;
    logic       start;
    logic [7:0] i_num_cnt;
    logic       i_mode;
    logic       i_auto_reload;
    logic [7:0] out;
    logic [7:0] o_cnt;
    logic       o_busy;
    logic       is_done_o;

    param_ring_counter #(.CNT_W(8), .RING_W(8)) dut (
        .clk           (clk),
        .rst           (rst),
        .en            (en),
        .start         (start),
        .i_num_cnt     (i_num_cnt),
        .i_mode        (i_mode),
        .i_auto_reload (i_auto_reload),
        .out           (out),
        .o_cnt         (o_cnt),
        .o_busy        (o_busy),
        .is_done_o     (is_done_o)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [7:0] eout;
        logic [7:0] ecnt;
        logic       ebusy;
        logic       edone;
        string      name;
    } exp_t;

    exp_t exp_q[$];
    int   pass_cnt  = 0;
    int   total_cnt = 0;

    logic [7:0] jt [0:10];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
        total_cnt++;
        if (act === req) begin
            pass_cnt++;
        end else begin
            $display("FAIL %s: got %0h, required %0h", nm, act, req);
        end
    endtask

    // Drive one cycle of stimulus and queue what the DUT must show after the
    // following rising edge.
    task automatic step(input logic s, input logic e, input logic [7:0] n,
                        input logic m, input logic r,
                        input logic [7:0] eo, input logic [7:0] ec,
                        input logic eb, input logic ed, input string nm);
        exp_t x;
        @(negedge clk);
        start         = s;
        en            = e;
        i_num_cnt     = n;
        i_mode        = m;
        i_auto_reload = r;
        x.eout  = eo;
        x.ecnt  = ec;
        x.ebusy = eb;
        x.edone = ed;
        x.name  = nm;
        exp_q.push_back(x);
    endtask

    // Non-start cycle; config inputs carry junk that must be ignored.
    task automatic adv(input logic e, input logic [7:0] eo, input logic [7:0] ec,
                       input logic eb, input logic ed, input string nm);
        step(1'b0, e, 8'd2, 1'b1, 1'b1, eo, ec, eb, ed, nm);
    endtask

    // Monitor: outputs are registered and presented every cycle.
    always @(posedge clk) begin
        exp_t x;
        #2;
        if (exp_q.size() > 0) begin
            x = exp_q.pop_front();
            chk({x.name, ".out"},  32'(out),       32'(x.eout));
            chk({x.name, ".cnt"},  32'(o_cnt),     32'(x.ecnt));
            chk({x.name, ".busy"}, 32'(o_busy),    32'(x.ebusy));
            chk({x.name, ".done"}, 32'(is_done_o), 32'(x.edone));
            $display("check %s: out=%02h cnt=%0d busy=%0b done=%0b", x.name, out, o_cnt, o_busy, is_done_o);
        end
    end

    initial begin
        jt = '{8'h00, 8'h01, 8'h03, 8'h07, 8'h0F, 8'h1F, 8'h3F, 8'h7F, 8'hFF, 8'hFE, 8'hFC};
        rst = 1'b1; en = 1'b0; start = 1'b0;
        i_num_cnt = 8'd0; i_mode = 1'b0; i_auto_reload = 1'b0;
        #50 rst = 1'b0;

        // Reset state; en without start does nothing.
        for (int i = 0; i < 3; i++) adv(1'b1, 8'h01, 8'd0, 1'b0, 1'b0, "rst_idle");

        // One-hot one-shot, N = 10.
        step(1'b1, 1'b0, 8'd10, 1'b0, 1'b0, 8'h01, 8'd0, 1'b1, 1'b0, "oh_start");
        for (int k = 1; k <= 10; k++)
            adv(1'b1, 8'(8'h01 << (k % 8)), (k == 10) ? 8'd0 : 8'(k), k != 10, k == 10, "oh_adv");
        adv(1'b1, 8'h04, 8'd0, 1'b0, 1'b0, "oh_idle");

        // Johnson one-shot, N = 10.
        step(1'b1, 1'b1, 8'd10, 1'b1, 1'b0, 8'h00, 8'd0, 1'b1, 1'b0, "jn_start");
        for (int k = 1; k <= 10; k++)
            adv(1'b1, jt[k], (k == 10) ? 8'd0 : 8'(k), k != 10, k == 10, "jn_adv");
        adv(1'b1, 8'hFC, 8'd0, 1'b0, 1'b0, "jn_idle");

        // Auto-reload N = 3 with a pause cycle.
        step(1'b1, 1'b1, 8'd3, 1'b0, 1'b1, 8'h01, 8'd0, 1'b1, 1'b0, "ar_start");
        adv(1'b1, 8'h02, 8'd1, 1'b1, 1'b0, "ar_a1");
        adv(1'b1, 8'h04, 8'd2, 1'b1, 1'b0, "ar_a2");
        adv(1'b0, 8'h04, 8'd2, 1'b1, 1'b0, "ar_hold");
        adv(1'b1, 8'h08, 8'd0, 1'b1, 1'b1, "ar_a3");
        adv(1'b1, 8'h10, 8'd1, 1'b1, 1'b0, "ar_a4");
        adv(1'b1, 8'h20, 8'd2, 1'b1, 1'b0, "ar_a5");
        adv(1'b1, 8'h40, 8'd0, 1'b1, 1'b1, "ar_a6");

        // N = 0 while running: immediate done, never busy.
        step(1'b1, 1'b1, 8'd0, 1'b0, 1'b0, 8'h01, 8'd0, 1'b0, 1'b1, "n0_start");
        adv(1'b1, 8'h01, 8'd0, 1'b0, 1'b0, "n0_after");

        // N = 1 with reload: done every cycle.
        step(1'b1, 1'b0, 8'd1, 1'b0, 1'b1, 8'h01, 8'd0, 1'b1, 1'b0, "n1_start");
        for (int k = 1; k <= 4; k++)
            adv(1'b1, 8'(8'h01 << k), 8'd0, 1'b1, 1'b1, "n1_adv");

        // Restart at o_cnt = 5 with new N = 4 in Johnson mode.
        step(1'b1, 1'b0, 8'd10, 1'b0, 1'b0, 8'h01, 8'd0, 1'b1, 1'b0, "rs_start");
        for (int k = 1; k <= 5; k++)
            adv(1'b1, 8'(8'h01 << k), 8'(k), 1'b1, 1'b0, "rs_adv");
        step(1'b1, 1'b1, 8'd4, 1'b1, 1'b0, 8'h00, 8'd0, 1'b1, 1'b0, "rs_restart");
        for (int k = 1; k <= 4; k++)
            adv(1'b1, jt[k], (k == 4) ? 8'd0 : 8'(k), k != 4, k == 4, "rs_newn");

        // Reset mid-run.
        step(1'b1, 1'b0, 8'd10, 1'b1, 1'b0, 8'h00, 8'd0, 1'b1, 1'b0, "ab_start");
        for (int k = 1; k <= 3; k++)
            adv(1'b1, jt[k], 8'(k), 1'b1, 1'b0, "ab_adv");
        @(negedge clk);
        rst = 1'b1;
        en  = 1'b1;
        #1;
        chk("ab_async.out",  32'(out),       32'h01);
        chk("ab_async.cnt",  32'(o_cnt),     32'h0);
        chk("ab_async.busy", 32'(o_busy),    32'h0);
        chk("ab_async.done", 32'(is_done_o), 32'h0);
        adv(1'b1, 8'h01, 8'd0, 1'b0, 1'b0, "ab_inrst");
        @(negedge clk);
        rst = 1'b0;
        adv(1'b1, 8'h01, 8'd0, 1'b0, 1'b0, "ab_after");
        adv(1'b1, 8'h01, 8'd0, 1'b0, 1'b0, "ab_after2");

        for (int i = 0; i < 20 && exp_q.size() > 0; i++) @(posedge clk);
        #5;
        if (exp_q.size() != 0) chk("drain", 32'(exp_q.size()), 32'd0);
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
